// File: rtl/ex_flag_commit.sv
// Execute-to-memory commit stage: small result FIFO toward the memory stage,
// plus the architectural carry/zero flags fed back to the ALU.
module ex_flag_commit #(
    parameter int DATA_W = 16,
    parameter int DEST_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opc,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src0,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_allow,
    input  logic              in_wr_en,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_wr_en,
    output logic              flag_c,
    output logic              flag_z
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + DEST_W + 1;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  wr_entry;

    logic [DATA_W:0]   sum;
    logic              carry;
    logic              res_zero;
    logic              sets_c;
    logic              sets_z;
    logic              flag_c_nxt;
    logic              flag_z_nxt;

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high. in_ready depends only on the registered count (and reset),
    // never on out_ready; out_* hold steady while out_valid & ~out_ready.
    // A flush in the same cycle cancels both the push and the pop.
    assign in_ready  = reset_n & (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Squashed instructions still travel as bubbles, just without a write.
    assign wr_entry = {in_result, in_dest, in_wr_en & in_allow};
    assign {out_result, out_dest, out_wr_en} = mem[rd_ptr];

    // Carry is bit DATA_W of the widened sum; shifting keeps the whole sum live.
    assign sum      = {1'b0, in_src1} + {1'b0, in_src0};
    assign carry    = |(sum >> DATA_W);
    assign res_zero = (in_result == '0);

    always_comb begin
        sets_c = 1'b0;
        sets_z = 1'b0;
        case (in_opc)
            3'b001, 3'b010: begin
                sets_c = 1'b1;
                sets_z = 1'b1;
            end
            3'b011, 3'b100, 3'b101, 3'b110: begin
                sets_z = 1'b1;
            end
            default: begin
                sets_c = 1'b0;
                sets_z = 1'b0;
            end
        endcase
    end

    always_comb begin
        flag_c_nxt = flag_c;
        flag_z_nxt = flag_z;
        if (push && in_allow) begin
            if (sets_c) flag_c_nxt = carry;
            if (sets_z) flag_z_nxt = res_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so out_* read as zero until the first push.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // push already excludes the flush cycle, so flushed input never touches flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            flag_c <= flag_c_nxt;
            flag_z <= flag_z_nxt;
        end
    end

endmodule

// File: tb/tb_ex_flag_commit.sv
// Self-checking bench for ex_flag_commit: directed scenario tasks plus a
// negedge scoreboard tracking FIFO contents and the flag model.
module tb_ex_flag_commit;

    localparam int DATA_W = 16;
    localparam int DEST_W = 3;
    localparam int DEPTH  = 2;
    localparam int ENT_W  = DATA_W + DEST_W + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_opc = '0;
    logic [DATA_W-1:0] in_src1 = '0;
    logic [DATA_W-1:0] in_src0 = '0;
    logic [DATA_W-1:0] in_result = '0;
    logic              in_allow = 1'b0;
    logic              in_wr_en = 1'b0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [DEST_W-1:0] out_dest;
    logic              out_wr_en;
    logic              flag_c;
    logic              flag_z;

    int checks = 0;
    int errors = 0;
    logic [ENT_W-1:0] exp_q[$];
    bit   mon_en  = 1'b0;
    logic model_c = 1'b0;
    logic model_z = 1'b0;

    ex_flag_commit #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
        .in_src1(in_src1), .in_src0(in_src0), .in_result(in_result),
        .in_allow(in_allow), .in_wr_en(in_wr_en), .in_dest(in_dest),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_wr_en(out_wr_en),
        .flag_c(flag_c), .flag_z(flag_z)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // scoreboard: compares at negedge, then advances the model for the next edge
    always @(negedge clk) begin : monitor
        logic              acc;
        logic [ENT_W-1:0]  got;
        logic [ENT_W-1:0]  exp;
        logic [DATA_W:0]   s;
        if (mon_en) begin
            checks++;
            if (flag_c !== model_c || flag_z !== model_z) begin
                errors++;
                $display("FAIL sb_flags: got c=%0b z=%0b expected c=%0b z=%0b", flag_c, flag_z, model_c, model_z);
            end
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL sb_out_valid: got %0b expected %0b", out_valid, exp_q.size() != 0);
            end
            checks++;
            if (in_ready !== (reset_n && exp_q.size() < DEPTH)) begin
                errors++;
                $display("FAIL sb_in_ready: got %0b expected %0b", in_ready, reset_n && exp_q.size() < DEPTH);
            end
            if (!reset_n) begin
                exp_q.delete();
                model_c = 1'b0;
                model_z = 1'b0;
            end else if (flush) begin
                exp_q.delete();
            end else begin
                acc = in_valid && (exp_q.size() < DEPTH);
                if (exp_q.size() != 0 && out_ready) begin
                    got = {out_result, out_dest, out_wr_en};
                    exp = exp_q.pop_front();
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_entry: got res=%h dest=%0d we=%0b expected res=%h dest=%0d we=%0b",
                                 out_result, out_dest, out_wr_en,
                                 exp[ENT_W-1 -: DATA_W], exp[DEST_W:1], exp[0]);
                    end
                end
                if (acc) begin
                    exp_q.push_back({in_result, in_dest, in_wr_en & in_allow});
                    s = {1'b0, in_src1} + {1'b0, in_src0};
                    if (in_allow) begin
                        case (in_opc)
                            3'b001, 3'b010: begin
                                model_c = s[DATA_W];
                                model_z = (in_result == 0);
                            end
                            3'b011, 3'b100, 3'b101, 3'b110: model_z = (in_result == 0);
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic push_one(input logic [2:0] opc, input logic [15:0] s1, input logic [15:0] s0,
                            input logic [15:0] res, input logic allow, input logic wr,
                            input logic [2:0] dest);
        bit ok = 1'b0;
        in_opc = opc; in_src1 = s1; in_src0 = s0; in_result = res;
        in_allow = allow; in_wr_en = wr; in_dest = dest; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: out_valid stayed %0b, required 0 within 50 cycles", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
        end
        checks++;
        if (flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: c=%0b z=%0b required 0 0", flag_c, flag_z);
        end
        checks++;
        if (out_result !== 16'h0000 || out_dest !== 3'd0 || out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: res=%h dest=%0d we=%0b required 0000 0 0", out_result, out_dest, out_wr_en);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry();
        out_ready = 1'b1;
        push_one(3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 3'd3);
        @(negedge clk);
        checks++;
        if (flag_c !== 1'b1 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL carry_flags: c=%0b z=%0b required 1 1", flag_c, flag_z);
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h0000 || out_dest !== 3'd3 || out_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL carry_entry: v=%0b res=%h dest=%0d we=%0b required 1 0000 3 1",
                     out_valid, out_result, out_dest, out_wr_en);
        end
        wait_empty();
    endtask

    task automatic test_squash();
        out_ready = 1'b1;
        push_one(3'b010, 16'h0001, 16'h0001, 16'h1234, 1'b0, 1'b1, 3'd5);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_wr_en !== 1'b0 || out_dest !== 3'd5) begin
            errors++;
            $display("FAIL squash_entry: v=%0b we=%0b dest=%0d required 1 0 5", out_valid, out_wr_en, out_dest);
        end
        checks++;
        if (flag_c !== 1'b1 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL squash_flags: c=%0b z=%0b required 1 1", flag_c, flag_z);
        end
        wait_empty();
    endtask

    task automatic test_full_backpressure();
        logic [15:0] d;
        out_ready = 1'b0;
        push_one(3'b000, 16'h0001, 16'h0002, 16'h1111, 1'b1, 1'b1, 3'd1);
        push_one(3'b111, 16'h0003, 16'h0004, 16'h2222, 1'b1, 1'b1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 16'h1111) begin
                errors++;
                $display("FAIL full_hold: in_ready=%0b v=%0b res=%h required 0 1 1111", in_ready, out_valid, out_result);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_result !== 16'h1111) begin
            errors++;
            $display("FAIL order_a: res=%h required 1111", out_result);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h2222) begin
            errors++;
            $display("FAIL order_b: v=%0b res=%h required 1 2222", out_valid, out_result);
        end
        @(posedge clk); #1;
        // streaming: one push and one pop per cycle keeps a single entry in flight
        for (int i = 0; i < 5; i++) begin
            d = 16'h3000 + 16'(i);
            in_valid = 1'b1; in_opc = 3'b111; in_result = d; in_src1 = d; in_src0 = 16'h0;
            in_allow = 1'b1; in_wr_en = 1'b1; in_dest = 3'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: in_ready=%0b required 1", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== d - 16'h1) begin
                    errors++;
                    $display("FAIL stream_head[%0d]: v=%0b res=%h required 1 %h", i, out_valid, out_result, d - 16'h1);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_empty();
    endtask

    task automatic test_flush();
        // two entries queued, FIFO full during the flush
        out_ready = 1'b0;
        push_one(3'b001, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b1, 3'd1);
        push_one(3'b000, 16'h0000, 16'h0000, 16'h4444, 1'b1, 1'b1, 3'd2);
        flush = 1'b1; in_valid = 1'b1; in_opc = 3'b001;
        in_src1 = 16'hFFFF; in_src0 = 16'h0001; in_result = 16'h0000; in_allow = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: v=%0b rdy=%0b c=%0b z=%0b required 0 1 0 0", out_valid, in_ready, flag_c, flag_z);
        end
        @(posedge clk); #1;
        // one entry queued, so the stage would otherwise accept the offered input
        push_one(3'b000, 16'h0000, 16'h0000, 16'h5555, 1'b1, 1'b1, 3'd4);
        flush = 1'b1; in_valid = 1'b1; in_opc = 3'b001;
        in_src1 = 16'hFFFF; in_src0 = 16'h0001; in_result = 16'h0000; in_allow = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL flush_one: v=%0b c=%0b z=%0b required 0 0 0", out_valid, flag_c, flag_z);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_one(3'b111, 16'h0000, 16'h0000, 16'h6666, 1'b1, 1'b1, 3'd6);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 16'h6666 || out_dest !== 3'd6) begin
            errors++;
            $display("FAIL flush_after: v=%0b res=%h dest=%0d required 1 6666 6", out_valid, out_result, out_dest);
        end
        wait_empty();
    endtask

    task automatic test_nand_z_only();
        out_ready = 1'b1;
        push_one(3'b001, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b1, 3'd1);
        @(negedge clk);
        checks++;
        if (flag_c !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL nand_setup: c=%0b z=%0b required 1 0", flag_c, flag_z);
        end
        push_one(3'b100, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd2);
        @(negedge clk);
        checks++;
        if (flag_c !== 1'b1 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL nand_z: c=%0b z=%0b required 1 1", flag_c, flag_z);
        end
        push_one(3'b011, 16'h0000, 16'h0000, 16'h0005, 1'b1, 1'b1, 3'd3);
        @(negedge clk);
        checks++;
        if (flag_c !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL addz_z: c=%0b z=%0b required 1 0", flag_c, flag_z);
        end
        push_one(3'b101, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'd4);
        @(negedge clk);
        checks++;
        if (flag_c !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL nand_squash: c=%0b z=%0b required 1 0", flag_c, flag_z);
        end
        wait_empty();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push_one(3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 3'd1);
        push_one(3'b000, 16'h0000, 16'h0000, 16'h7777, 1'b1, 1'b1, 3'd2);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: v=%0b rdy=%0b c=%0b z=%0b required 0 1 0 0", out_valid, in_ready, flag_c, flag_z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opc    = 3'($urandom_range(0, 7));
            in_src1   = 16'($urandom_range(0, 16'hFFFF));
            in_src0   = 16'($urandom_range(0, 16'hFFFF));
            in_result = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'hFFFF));
            in_allow  = ($urandom_range(0, 3) != 0);
            in_wr_en  = 1'($urandom_range(0, 1));
            in_dest   = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        wait_empty();
    endtask

    initial begin
        test_reset();
        test_carry();
        test_squash();
        test_full_backpressure();
        test_flush();
        test_nand_z_only();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
